// File: rtl/mtimer.sv
// Memory-mapped 64-bit machine timer with prescaler, compare register and level interrupt.
// A read of MTIME_LO snapshots the high word so a LO-then-HI read pair sees one consistent value.
module mtimer (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        timer_interrupt
);

  typedef enum logic [2:0] {
    SEL_MTIME_LO    = 3'd0,
    SEL_MTIME_HI    = 3'd1,
    SEL_MTIMECMP_LO = 3'd2,
    SEL_MTIMECMP_HI = 3'd3,
    SEL_CTRL        = 3'd4
  } reg_sel_e;

  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic [31:0] r_hi_shadow;
  logic [7:0]  r_pcnt;
  logic [7:0]  r_presc;
  logic        r_en;
  logic        r_ie;
  logic        r_irq;

  reg_sel_e    w_sel;
  logic        w_aligned;
  logic        w_tick;
  logic        w_wr_mtime_lo;
  logic        w_wr_mtime_hi;
  logic        w_wr_cmp_lo;
  logic        w_wr_cmp_hi;
  logic        w_wr_ctrl;
  logic        w_rd_mtime_lo;

  assign w_sel         = reg_sel_e'(addr[4:2]);
  assign w_aligned     = (addr[1:0] == 2'b00);
  assign w_tick        = r_en && (r_pcnt == r_presc);
  assign w_wr_mtime_lo = wr_en && w_aligned && (w_sel == SEL_MTIME_LO);
  assign w_wr_mtime_hi = wr_en && w_aligned && (w_sel == SEL_MTIME_HI);
  assign w_wr_cmp_lo   = wr_en && w_aligned && (w_sel == SEL_MTIMECMP_LO);
  assign w_wr_cmp_hi   = wr_en && w_aligned && (w_sel == SEL_MTIMECMP_HI);
  assign w_wr_ctrl     = wr_en && w_aligned && (w_sel == SEL_CTRL);
  assign w_rd_mtime_lo = rd_en && w_aligned && (w_sel == SEL_MTIME_LO);

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mtime     <= '0;
      r_mtimecmp  <= '1;
      r_hi_shadow <= '0;
      r_pcnt      <= '0;
      r_presc     <= '0;
      r_en        <= 1'b0;
      r_ie        <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_en    <= wdata[0];
        r_ie    <= wdata[1];
        r_presc <= wdata[15:8];
      end

      if (w_wr_ctrl)
        r_pcnt <= '0;
      else if (r_en)
        r_pcnt <= w_tick ? 8'd0 : r_pcnt + 8'd1;

      // A software write to either half suppresses the tick entirely, carry included.
      if (w_wr_mtime_lo)
        r_mtime[31:0] <= wdata;
      else if (w_wr_mtime_hi)
        r_mtime[63:32] <= wdata;
      else if (w_tick)
        r_mtime <= r_mtime + 64'd1;

      if (w_wr_cmp_lo) r_mtimecmp[31:0]  <= wdata;
      if (w_wr_cmp_hi) r_mtimecmp[63:32] <= wdata;

      if (w_rd_mtime_lo) r_hi_shadow <= r_mtime[63:32];

      r_irq <= r_ie && (r_mtime >= r_mtimecmp);
    end
  end

  // NOTE: rdata gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    rdata = '0;
    if (rd_en && w_aligned) begin
      case (w_sel)
        SEL_MTIME_LO:    rdata = r_mtime[31:0];
        SEL_MTIME_HI:    rdata = r_hi_shadow;
        SEL_MTIMECMP_LO: rdata = r_mtimecmp[31:0];
        SEL_MTIMECMP_HI: rdata = r_mtimecmp[63:32];
        SEL_CTRL:        rdata = {16'h0000, r_presc, 6'b000000, r_ie, r_en};
        default:         rdata = '0;
      endcase
    end
  end

  assign timer_interrupt = r_irq;

endmodule

// File: doc/mtimer.md
MTIMER -- requirements
Module: mtimer

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port rd_en, input, 1, register read strobe from the MEM-WB stage, sampled with addr.
REQ-004 SHALL have port wr_en, input, 1, register write strobe, sampled on the rising edge.
REQ-005 SHALL have port addr, input, 5, byte address of the target register; only word-aligned offsets decode.
REQ-006 SHALL have port wdata, input, 32, write data.
REQ-007 SHALL have port rdata, output, 32, combinational read data.
REQ-008 SHALL have port timer_interrupt, output, 1, registered level interrupt to the processor trap input.

Function
REQ-009 SHALL implement this register map: 0x00 MTIME_LO, 0x04 MTIME_HI, 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI, 0x10 CTRL.
REQ-010 SHALL define CTRL bit0 as EN (count enable), bit1 as IE (interrupt enable) and bits[15:8] as PRESC; all other CTRL bits SHALL read 0 and ignore writes.
REQ-011 SHALL keep a 64-bit mtime counter and a 64-bit mtimecmp register.
REQ-012 SHALL keep an 8-bit prescale counter pcnt that increments every cycle while EN=1.
REQ-013 SHALL assert a one-cycle tick when EN=1 and pcnt==PRESC; on that cycle pcnt SHALL return to 0, so mtime advances once every PRESC+1 cycles.
REQ-014 SHALL, on a tick, increment mtime by 1 as a full 64-bit add: LO carries into HI, and the counter wraps from 0xFFFF_FFFF_FFFF_FFFF to 0.
REQ-015 SHALL hold both pcnt and mtime while EN=0.
REQ-016 SHALL clear pcnt on any CTRL write.
REQ-017 SHALL, on a write to MTIME_LO or MTIME_HI, replace only that 32-bit half.
REQ-018 SHALL give a software write priority over a same-cycle tick: the written half takes wdata, the other half does not increment, and no carry is applied.
REQ-019 SHALL make a write to MTIMECMP_LO or MTIMECMP_HI replace only that half.
REQ-020 SHALL make rdata a combinational decode of addr whenever rd_en=1, and SHALL drive 0 when rd_en=0 or addr is unmapped.
REQ-021 SHALL make a read of MTIME_LO return the current low word and, on that clock edge, capture the current high word into a shadow register hi_shadow.
REQ-022 SHALL make a read of MTIME_HI return hi_shadow, not the live high word, so a LO-then-HI sequence reads a consistent 64-bit value.
REQ-023 SHALL make reads of MTIMECMP and CTRL return the live register values.
REQ-024 SHALL ignore writes to unmapped addresses and to misaligned addresses (addr[1:0]!=0).
REQ-025 SHALL, when rd_en and wr_en are asserted together, return the pre-write value on rdata and commit the write on the edge.
REQ-026 SHALL register the interrupt as timer_interrupt <= IE & (mtime >= mtimecmp), an unsigned 64-bit compare on the current-cycle register values.
REQ-027 SHALL therefore update timer_interrupt one cycle after any change to mtime, mtimecmp or IE.
REQ-028 SHALL hold timer_interrupt at level until software raises mtimecmp above mtime or clears IE; the interrupt SHALL have no sticky pending bit.

Reset
REQ-029 SHALL, on rst, set mtime=0, pcnt=0 and hi_shadow=0.
REQ-030 SHALL, on rst, set mtimecmp=0xFFFF_FFFF_FFFF_FFFF, CTRL=0 and timer_interrupt=0.
REQ-031 SHALL give rst priority over any same-cycle write or tick, including reset during a counting run.
REQ-032 SHALL keep rdata a function of post-reset state only.

Verification
REQ-033 Prescale: CTRL=0x0000_0301 (EN=1, PRESC=3), run 12 cycles -> MTIME_LO reads 3.
REQ-034 Carry and wrap: write MTIME_HI=0, MTIME_LO=0xFFFF_FFFF, set EN with PRESC=0, wait one tick -> LO=0 and HI=1; separately, from 0xFFFF_FFFF_FFFF_FFFF one tick -> 0.
REQ-035 Atomic read: set mtime=0x0000_0000_FFFF_FFFF, read LO on the cycle before the carry, then read HI -> HI returns 0, not 1.
REQ-036 Interrupt: set mtimecmp=5, IE=1, EN=1, PRESC=0 -> timer_interrupt rises exactly one cycle after mtime reaches 5; write MTIMECMP_LO=100 -> it falls one cycle later.
REQ-037 Collision: drive a write of MTIME_LO=0x10 on a tick cycle -> LO=0x10 next cycle with no increment; assert rst mid-count -> all state returns to the REQ-029/REQ-030 values and timer_interrupt=0 next cycle.
